// File: rtl/sigmoid_backward_if.sv
// Handshake and data bundle between a sigmoid-gradient producer and the sigmoid_backward engine.
// No logic inside; timing is set entirely by the engine.
// The slave side accepts operands only while in_ready is high and holds results until out_ready.
interface sigmoid_backward_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] grad_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] grad_out;
  logic                    busy;

  // Operand source / result sink side.
  modport master (
    output in_valid, y_in, grad_in, out_ready,
    input  in_ready, out_valid, grad_out, busy
  );

  // Compute engine side.
  modport slave (
    input  in_valid, y_in, grad_in, out_ready,
    output in_ready, out_valid, grad_out, busy
  );
endinterface

// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_out = g * y * (1 - y) in signed Q(WIDTH-FRAC).FRAC, y clamped to [0, ONE].
// Latency: out_valid rises 2*WIDTH+1 edges after the accepting edge (two serial shift-add multiplies + sign fixup).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module sigmoid_backward #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  sigmoid_backward_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << FRAC;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FIN_CNT  = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;     // multiplicand, shifted left one place per step
  logic [WIDTH-1:0]   mplier_q;    // multiplier, consumed LSB first
  logic [2*WIDTH-1:0] acc_q;       // full-width partial product sum
  logic [WIDTH-1:0]   gmag_q;      // |g|, unsigned so -2^(WIDTH-1) has a representable magnitude
  logic               gneg_q;
  logic [WIDTH-1:0]   grad_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   y_raw;
  logic [WIDTH-1:0]   g_raw;
  logic [WIDTH-1:0]   y_clamp_d;
  logic [WIDTH-1:0]   gmag_d;
  logic [2*WIDTH-1:0] acc_step_d;
  logic [WIDTH-1:0]   d_d;
  logic [WIDTH-1:0]   m_d;
  logic [WIDTH-1:0]   res_d;

  assign y_raw = bus.y_in;
  assign g_raw = bus.grad_in;

  // Operand conditioning, one shift-add step, and the truncated/sign-corrected results.
  always_comb begin
    y_clamp_d = y_raw;
    if (y_raw[WIDTH-1]) begin
      y_clamp_d = '0;
    end else if (y_raw > ONE) begin
      y_clamp_d = ONE;
    end
    gmag_d     = g_raw[WIDTH-1] ? (WIDTH'(0) - g_raw) : g_raw;
    acc_step_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    // Truncating >> FRAC; both products are known to fit WIDTH bits after the shift.
    d_d        = acc_step_d[FRAC +: WIDTH];
    m_d        = acc_q[FRAC +: WIDTH];
    res_d      = gneg_q ? (WIDTH'(0) - m_d) : m_d;
  end

  // Control FSM with registered handshake outputs and the serial datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      gmag_q      <= '0;
      gneg_q      <= 1'b0;
      grad_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // First multiply: y * (ONE - y), y already clamped.
            mcand_q    <= {{WIDTH{1'b0}}, y_clamp_d};
            mplier_q   <= ONE - y_clamp_d;
            acc_q      <= '0;
            gmag_q     <= gmag_d;
            gneg_q     <= g_raw[WIDTH-1];
            cnt_q      <= '0;
            state_q    <= MUL1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MUL1: begin
          if (cnt_q == LAST_BIT) begin
            // Last bit of the first product: hand d straight over as the second multiplier.
            mcand_q  <= {{WIDTH{1'b0}}, gmag_q};
            mplier_q <= d_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL2;
          end else begin
            acc_q    <= acc_step_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        MUL2: begin
          if (cnt_q == FIN_CNT) begin
            // Extra cycle after the WIDTH steps: truncate and restore the sign of g.
            grad_q      <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            acc_q    <= acc_step_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.grad_out  = grad_q;

endmodule

// File: tb/tb_sigmoid_backward.sv
// Directed + random bench for sigmoid_backward with a result scoreboard.
// Checks reset state, latency, values, clamping, backpressure hold and mid-operation reset.
// Expected values are spec constants or an arithmetic reference model.
module tb_sigmoid_backward;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sigmoid_backward_if #(.WIDTH(32)) bus ();

  sigmoid_backward #(.WIDTH(32), .FRAC(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic with the same clamp and truncation rules.
  function automatic logic [31:0] model(input logic [31:0] y, input logic [31:0] g);
    logic [63:0] yc, d, mag, m;
    if (y[31])                  yc = 64'd0;
    else if (y > 32'h0100_0000) yc = 64'h0100_0000;
    else                        yc = {32'd0, y};
    d   = (yc * (64'h0100_0000 - yc)) >> 24;
    mag = g[31] ? {32'd0, (~g + 32'd1)} : {32'd0, g};
    m   = (mag * d) >> 24;
    return g[31] ? (32'd0 - m[31:0]) : m[31:0];
  endfunction

  // Present one operand pair and consume the accepting edge; optionally keep in_valid high with junk.
  task automatic start(input logic [31:0] y, input logic [31:0] g, input logic [31:0] exp, input bit junk);
    @(negedge clk);
    check_bit("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.y_in     = y;
    bus.grad_in  = g;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (junk) begin
      bus.y_in    = 32'h0040_0000;
      bus.grad_in = 32'h7FFF_FFFF;
    end else begin
      bus.in_valid = 1'b0;
    end
  endtask

  // Wait for the result, check latency/value, hold in DONE for 'hold' cycles, then release.
  task automatic finish(input int hold, input bit junk);
    int          edges;
    logic [31:0] exp;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      if (junk && edges == 30) bus.in_valid = 1'b0;
    end while (!bus.out_valid && edges < 200);
    check("latency", 32'(edges), 32'd65);
    check_bit("done_out_valid", bus.out_valid, 1'b1);
    check_bit("done_in_ready", bus.in_ready, 1'b0);
    check_bit("done_busy", bus.busy, 1'b1);
    exp = 32'd0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
    end else begin
      exp = sb_q.pop_front();
      check("result", bus.grad_out, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_grad_out", bus.grad_out, exp);
      check_bit("bp_out_valid", bus.out_valid, 1'b1);
      check_bit("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_bit("rel_in_ready", bus.in_ready, 1'b1);
    check_bit("rel_out_valid", bus.out_valid, 1'b0);
    check_bit("rel_busy", bus.busy, 1'b0);
    check("retain_grad_out", bus.grad_out, exp);
  endtask

  task automatic run_op(input logic [31:0] y, input logic [31:0] g, input logic [31:0] exp,
                        input int hold, input bit junk);
    start(y, g, exp, junk);
    finish(hold, junk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ry, rg;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.y_in      = '0;
    bus.grad_in   = '0;

    // Reset asserted before the first clock edge, then held with the clock running.
    #1 rst_n = 1'b0;
    #2;
    check_bit("rst_in_ready_noclk", bus.in_ready, 1'b1);
    check_bit("rst_out_valid_noclk", bus.out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    check("rst_grad_out", bus.grad_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic values, sign handling and in_valid ignored while busy.
    run_op(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 0, 1'b0);
    run_op(32'h00C0_0000, 32'h0100_0000, 32'h0030_0000, 0, 1'b1);
    run_op(32'h0080_0000, 32'hFE00_0000, 32'hFF80_0000, 0, 1'b0);

    // Clamping of y at and beyond both ends of the range.
    run_op(32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0100_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0100_0000, 32'h0000_0000, 0, 1'b0);

    // Output backpressure for 10 cycles.
    run_op(32'h00C0_0000, 32'h0100_0000, 32'h0030_0000, 10, 1'b0);

    // Most negative gradient.
    run_op(32'h0080_0000, 32'h8000_0000, 32'hE000_0000, 0, 1'b0);

    // Reset in the middle of the second multiply aborts the pair.
    start(32'h0080_0000, 32'hFE00_0000, 32'hFF80_0000, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    check_bit("mid_rst_in_ready", bus.in_ready, 1'b1);
    check_bit("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_grad_out", bus.grad_out, 32'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_bit("mid_rst_hold_out_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0080_0000, 32'h0100_0000, 32'h0040_0000, 0, 1'b0);

    // Random operands against the reference model, y spread around [0, ONE].
    for (int i = 0; i < 6; i++) begin
      ry = $urandom_range(32'h0140_0000, 0);
      if (i == 4) ry = 32'hFFF0_0000 | ry;
      rg = $urandom;
      run_op(ry, rg, model(ry, rg), (i == 2) ? 3 : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigmoid_backward.md
SIGMOID_BACKWARD -- requirements
Module: sigmoid_backward

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width.
REQ-002 SHALL have parameter FRAC, default 24: fractional bits. All data is signed fixed-point Q(WIDTH-FRAC).FRAC; ONE = 1 << FRAC.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: an operand pair is presented.
REQ-007 Port in_ready, output, 1: the block can accept an operand pair.
REQ-008 Port y_in, input, WIDTH, signed: forward sigmoid output y.
REQ-009 Port grad_in, input, WIDTH, signed: upstream gradient g.
REQ-010 Port out_valid, output, 1: the result is valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port grad_out, output, WIDTH, signed: computed g*y*(1-y).
REQ-013 Port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, MUL1, MUL2 and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On the rising edge with in_valid=1 in IDLE:
- SHALL capture y_in and grad_in;
- SHALL enter MUL1.
REQ-017 in_valid in any state other than IDLE SHALL be ignored.
REQ-018 Captured y SHALL be clamped to [0, ONE]: negative becomes 0, greater than ONE becomes ONE.
REQ-019 MUL1 SHALL compute d = (y*(ONE-y)) >> FRAC, unsigned:
- sequential shift-add, one multiplier bit per cycle;
- exactly WIDTH cycles;
- truncation, no rounding.
REQ-020 MUL2 SHALL compute m = (|g|*d) >> FRAC:
- same shift-add method, exactly WIDTH cycles;
- |g| held in a WIDTH-bit unsigned register, so g = -2^(WIDTH-1) yields magnitude 2^(WIDTH-1) without overflow.
REQ-021 Partial products SHALL be 2*WIDTH bits wide; no intermediate truncation before the final shift.
REQ-022 Result SHALL be -m if g < 0, else m. No saturation is required, since |result| <= |g|/4.
REQ-023 Latency: out_valid SHALL rise exactly 2*WIDTH+1 clock edges after the accepting edge (65 for WIDTH=32).
REQ-024 In DONE, grad_out and out_valid SHALL hold stable until a rising edge with out_ready=1; the FSM then returns to IDLE.
REQ-025 grad_out SHALL retain the last result after leaving DONE, until the next DONE overwrites it.
REQ-026 There SHALL be no input/output overlap: a new operand pair is accepted no earlier than the edge after the DONE->IDLE transition.
REQ-027 Results SHALL be bit-exact to the truncation rules above; the verification model shall use the same truncations.

Reset
REQ-028 While rst_n=0, regardless of clk:
- state SHALL be IDLE;
- in_ready SHALL be 1;
- out_valid, busy and grad_out SHALL be 0;
- all datapath registers SHALL be 0.
REQ-029 Reset asserted mid-operation (MUL1, MUL2 or DONE) SHALL abort the operation; no result is produced for the aborted pair.
REQ-030 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-031 y_in=0x00800000, grad_in=0x01000000 -> grad_out=0x00400000 (0.25), with out_valid rising exactly 65 edges after acceptance.
REQ-032 y_in=0x00C00000 (0.75), grad_in=0x01000000 -> grad_out=0x00300000; y_in=0x00800000, grad_in=0xFE000000 (-2.0) -> grad_out=0xFF800000 (-0.5).
REQ-033 Clamping: y_in=0x01000000, 0x7FFFFFFF or 0x80000000, each with grad_in=0x01000000 -> grad_out=0x00000000.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> grad_out stable, out_valid=1 and in_ready=0 throughout. Then out_ready=1 for one edge -> in_ready=1 the next cycle.
REQ-035 Extreme gradient: y_in=0x00800000, grad_in=0x80000000 -> grad_out=0xE0000000 (-32.0), no overflow.
REQ-036 Reset mid-MUL2, then a new pair y_in=0x00800000, grad_in=0x01000000 -> no stale out_valid; the new result is 0x00400000 after 65 edges.
